// File: rtl/pio_in_edge_irq_pkg.sv
// Shared constants for the edge-capturing input PIO: register offsets,
// edge-mode selectors, bus width and the per-bit edge selection helper.
package pio_pkg;

    localparam int PIO_BUS_W = 32;

    localparam logic [1:0] PIO_OFS_DATA = 2'd0;
    localparam logic [1:0] PIO_OFS_RSVD = 2'd1;
    localparam logic [1:0] PIO_OFS_MASK = 2'd2;
    localparam logic [1:0] PIO_OFS_EDGE = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // An unsupported mode captures nothing rather than guessing a polarity.
    function automatic logic edge_sel(input int mode, input logic cur, input logic prev);
        logic res;
        case (mode)
            EDGE_RISE: res = cur & ~prev;
            EDGE_FALL: res = ~cur & prev;
            EDGE_ANY:  res = cur ^ prev;
            default:   res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/pio_in_edge_irq_if.sv
// Avalon-MM slave bus bundle for the edge-capturing input PIO.
interface pio_in_edge_irq_if;
    import pio_pkg::*;

    logic [1:0]           address;
    logic                 chipselect;
    logic                 write_n;
    logic [PIO_BUS_W-1:0] writedata;
    logic [PIO_BUS_W-1:0] readdata;

    modport master (output address, output chipselect, output write_n,
                    output writedata, input readdata);
    modport slave  (input address, input chipselect, input write_n,
                    input writedata, output readdata);
endinterface

// File: rtl/pio_in_edge_irq_bit_cond.sv
// One input bit: synchroniser, optional debounce filter (PIO_DEBOUNCE_EN)
// and edge pulse generation gated by the priming enable.
module pio_bit_cond
    import pio_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
`ifdef PIO_DEBOUNCE_EN
    parameter int DEBOUNCE_CYCLES = 1024,
`endif
    parameter int EDGE_MODE = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_arm,
    input  logic i_pin,
    output logic o_level,
    output logic o_edge
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_sync_in;
    logic                   w_level;

    // synchroniser chain, bit 0 samples the asynchronous pin
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
        end
    end

    assign w_sync_in = r_sync[SYNC_STAGES-1];

`ifdef PIO_DEBOUNCE_EN
    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_filt;

    // follow sync_in only once it has disagreed for DEBOUNCE_CYCLES cycles in a row
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt  <= '0;
            r_filt <= 1'b0;
        end else if (w_sync_in == r_filt) begin
            r_cnt  <= '0;
            r_filt <= r_filt;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt  <= '0;
            r_filt <= w_sync_in;
        end else begin
            r_cnt  <= r_cnt + CNT_W'(1);
            r_filt <= r_filt;
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = w_sync_in;
`endif

    // previous level for edge comparison
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_level;
        end
    end

    assign o_level = w_level;
    assign o_edge  = i_arm & edge_sel(EDGE_MODE, w_level, r_prev);

endmodule

// File: rtl/pio_in_edge_irq.sv
// Input-only Avalon-MM PIO with sticky per-bit edge capture and a maskable
// level interrupt. Define PIO_DEBOUNCE_EN to insert a per-bit debounce filter.
module pio_in_edge_irq
    import pio_pkg::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter int EDGE_MODE       = 0,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    pio_in_edge_irq_if.slave      bus,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic                  irq
);

    if (DATA_WIDTH < 1 || DATA_WIDTH > PIO_BUS_W) begin : g_bad_width
        $error("pio_in_edge_irq: DATA_WIDTH must be 1..32");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("pio_in_edge_irq: SYNC_STAGES must be 2..4");
    end
    if (EDGE_MODE < EDGE_RISE || EDGE_MODE > EDGE_ANY) begin : g_bad_mode
        $error("pio_in_edge_irq: EDGE_MODE must be 0..2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("pio_in_edge_irq: DEBOUNCE_CYCLES must be at least 1");
    end

    // Edges stay gated until reset zeros have flushed through sync and prev.
    localparam int                  PRIME_MAX  = SYNC_STAGES + 1;
    localparam int                  PRIME_W    = $clog2(PRIME_MAX + 1);
    localparam logic [PRIME_W-1:0] PRIME_DONE = PRIME_W'(PRIME_MAX);

    logic [PRIME_W-1:0]    r_prime;
    logic                  w_armed;
    logic [DATA_WIDTH-1:0] w_level;
    logic [DATA_WIDTH-1:0] w_edge;
    logic [DATA_WIDTH-1:0] r_mask;
    logic [DATA_WIDTH-1:0] r_edgecap;
    logic [DATA_WIDTH-1:0] w_mask_nxt;
    logic [DATA_WIDTH-1:0] w_edgecap_nxt;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_rd_field;
    logic [PIO_BUS_W-1:0]  w_rd_nxt;
    logic [PIO_BUS_W-1:0]  r_readdata;
    logic                  r_irq;
    logic                  w_wr;

    // priming counter, saturates once edges may be trusted
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prime <= '0;
        end else if (r_prime != PRIME_DONE) begin
            r_prime <= r_prime + PRIME_W'(1);
        end else begin
            r_prime <= r_prime;
        end
    end

    assign w_armed = (r_prime == PRIME_DONE);

    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
        pio_bit_cond #(
            .SYNC_STAGES     (SYNC_STAGES),
`ifdef PIO_DEBOUNCE_EN
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
`endif
            .EDGE_MODE       (EDGE_MODE)
        ) u_cond (
            .clk     (clk),
            .reset   (reset),
            .i_arm   (w_armed),
            .i_pin   (in_port[gi]),
            .o_level (w_level[gi]),
            .o_edge  (w_edge[gi])
        );
    end

    assign w_wr    = bus.chipselect & ~bus.write_n;
    assign w_wdata = bus.writedata[DATA_WIDTH-1:0];

    // register write decode; a fresh edge overrides a same-cycle clear
    always_comb begin
        w_mask_nxt    = r_mask;
        w_edgecap_nxt = r_edgecap | w_edge;
        if (w_wr && (bus.address == PIO_OFS_MASK)) begin
            w_mask_nxt = w_wdata;
        end else begin
            w_mask_nxt = r_mask;
        end
        if (w_wr && (bus.address == PIO_OFS_EDGE)) begin
            w_edgecap_nxt = (r_edgecap & ~w_wdata) | w_edge;
        end else begin
            w_edgecap_nxt = r_edgecap | w_edge;
        end
    end

    // read mux, zero-extended to the bus width
    always_comb begin
        w_rd_field = '0;
        case (bus.address)
            PIO_OFS_DATA: w_rd_field = w_level;
            PIO_OFS_MASK: w_rd_field = r_mask;
            PIO_OFS_EDGE: w_rd_field = r_edgecap;
            default:      w_rd_field = '0;
        endcase
        w_rd_nxt                 = '0;
        w_rd_nxt[DATA_WIDTH-1:0] = w_rd_field;
    end

    // architectural registers, read data and interrupt
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask     <= '0;
            r_edgecap  <= '0;
            r_readdata <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_mask     <= w_mask_nxt;
            r_edgecap  <= w_edgecap_nxt;
            r_readdata <= w_rd_nxt;
            r_irq      <= |(r_edgecap & r_mask);
        end
    end

    assign bus.readdata = r_readdata;
    assign irq          = r_irq;

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Self-checking bench: a rising-edge and an any-edge instance share one bus
// and one input; a history-based model is compared against both every cycle.
module tb_pio_in_edge_irq;
    import pio_pkg::*;

    localparam int DW = 16;
    localparam int S  = 2;
    localparam int DB = 8;
`ifdef PIO_DEBOUNCE_EN
    localparam int          CAP_LAT = S + 1 + DB;
    localparam logic [31:0] RST_CAP = 32'h0000A5C3;
`else
    localparam int          CAP_LAT = S + 1;
    localparam logic [31:0] RST_CAP = 32'h00000000;
`endif

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    addr  = 2'd0;
    logic          cs    = 1'b0;
    logic          wn    = 1'b1;
    logic [31:0]   wdata = 32'd0;
    logic [DW-1:0] pin   = 16'hA5C3;
    logic          irq0;
    logic          irq1;
    int            n_checks = 0;
    int            n_pass   = 0;

    always #5 clk = ~clk;

    pio_in_edge_irq_if bus0 ();
    pio_in_edge_irq_if bus1 ();

    assign bus0.address    = addr;
    assign bus0.chipselect = cs;
    assign bus0.write_n    = wn;
    assign bus0.writedata  = wdata;
    assign bus1.address    = addr;
    assign bus1.chipselect = cs;
    assign bus1.write_n    = wn;
    assign bus1.writedata  = wdata;

    pio_in_edge_irq #(.DATA_WIDTH(DW), .EDGE_MODE(EDGE_RISE), .SYNC_STAGES(S),
                      .DEBOUNCE_CYCLES(DB)) dut_rise (
        .clk(clk), .reset(reset), .bus(bus0), .in_port(pin), .irq(irq0));

    pio_in_edge_irq #(.DATA_WIDTH(DW), .EDGE_MODE(EDGE_ANY), .SYNC_STAGES(S),
                      .DEBOUNCE_CYCLES(DB)) dut_any (
        .clk(clk), .reset(reset), .bus(bus1), .in_port(pin), .irq(irq1));

    // Model: the pin value seen S edges ago is the synchronised value.
    logic [DW-1:0] pin_hist[$];
    logic [DW-1:0] sync_hist[$];
    int            edges_since_rst;
    logic [DW-1:0] m_lvl_prev, m_filt, m_mask;
    logic [DW-1:0] m_cap[2];
    logic [31:0]   m_rd[2];
    logic          m_irq[2];
    bit            m_valid = 1'b0;

    always @(posedge clk) begin : model
        logic [DW-1:0] s_now, lvl, rise, fall, clr, ev;
        bit            stable;
        m_valid = 1'b1;
        if (reset) begin
            pin_hist.delete();
            for (int k = 0; k < S; k++) pin_hist.push_back('0);
            sync_hist.delete();
            edges_since_rst = 0;
            m_lvl_prev = '0;
            m_filt     = '0;
            m_mask     = '0;
            for (int d = 0; d < 2; d++) begin
                m_cap[d] = '0;
                m_rd[d]  = 32'd0;
                m_irq[d] = 1'b0;
            end
        end else begin
            s_now = pin_hist[0];
`ifdef PIO_DEBOUNCE_EN
            lvl = m_filt;
            sync_hist.push_back(s_now);
            if (sync_hist.size() > DB) void'(sync_hist.pop_front());
            if (sync_hist.size() == DB) begin
                for (int b = 0; b < DW; b++) begin
                    stable = 1'b1;
                    for (int k = 0; k < DB; k++)
                        if (sync_hist[k][b] == m_filt[b]) stable = 1'b0;
                    if (stable) m_filt[b] = s_now[b];
                end
            end
`else
            lvl = s_now;
`endif
            rise = (edges_since_rst >= S + 1) ? (lvl & ~m_lvl_prev) : '0;
            fall = (edges_since_rst >= S + 1) ? (~lvl & m_lvl_prev) : '0;
            clr  = (cs && !wn && addr == 2'd3) ? wdata[DW-1:0] : '0;
            for (int d = 0; d < 2; d++) begin
                ev       = (d == 0) ? rise : (rise | fall);
                m_irq[d] = |(m_cap[d] & m_mask);
                case (addr)
                    2'd0:    m_rd[d] = {16'd0, lvl};
                    2'd2:    m_rd[d] = {16'd0, m_mask};
                    2'd3:    m_rd[d] = {16'd0, m_cap[d]};
                    default: m_rd[d] = 32'd0;
                endcase
                m_cap[d] = (m_cap[d] & ~clr) | ev;
            end
            if (cs && !wn && addr == 2'd2) m_mask = wdata[DW-1:0];
            m_lvl_prev = lvl;
            void'(pin_hist.pop_front());
            pin_hist.push_back(pin);
            if (edges_since_rst < 1000) edges_since_rst++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    // literal expectation applied to both the DUT and the model
    task automatic lit(input string name, input logic [31:0] dut, input logic [31:0] mdl,
                       input logic [31:0] exp);
        check({name, "_dut"}, dut, exp);
        check({name, "_model"}, mdl, exp);
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("rd_rise", bus0.readdata, m_rd[0]);
            check("rd_any", bus1.readdata, m_rd[1]);
            check("irq_rise", {31'd0, irq0}, {31'd0, m_irq[0]});
            check("irq_any", {31'd0, irq1}, {31'd0, m_irq[1]});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        cs    = 1'b1;
        wn    = 1'b0;
        tick(1);
        cs    = 1'b0;
        wn    = 1'b1;
        wdata = 32'd0;
    endtask

    initial begin
        // reset with the pins held, then read data and edgecapture
        tick(3);
        reset = 1'b0;
        addr  = 2'd0;
        tick(CAP_LAT + 16);
        lit("rst_data_rise", bus0.readdata, m_rd[0], 32'h0000A5C3);
        lit("rst_data_any", bus1.readdata, m_rd[1], 32'h0000A5C3);
        addr = 2'd3;
        tick(1);
        lit("rst_edge", bus0.readdata, m_rd[0], RST_CAP);
        lit("rst_irq", {31'd0, irq0}, {31'd0, m_irq[0]}, 32'd0);

        // bit0 0->1 with mask bit0 set
        pin = 16'hA5C2;
        tick(CAP_LAT + 3);
        bus_write(2'd3, 32'h0000FFFF);
        bus_write(2'd2, 32'h00000001);
        addr = 2'd3;
        tick(2);
        pin = 16'hA5C3;
        tick(CAP_LAT);
        lit("rise_irq_early", {31'd0, irq0}, {31'd0, m_irq[0]}, 32'd0);
        tick(1);
        lit("rise_cap", bus0.readdata, m_rd[0], 32'h00000001);
        lit("rise_irq", {31'd0, irq0}, {31'd0, m_irq[0]}, 32'd1);

        // write-0 keeps, write-1 clears
        bus_write(2'd3, 32'h00000000);
        tick(1);
        lit("w0_keep", bus0.readdata, m_rd[0], 32'h00000001);
        bus_write(2'd3, 32'h00000001);
        lit("w1c_irq_hold", {31'd0, irq0}, {31'd0, m_irq[0]}, 32'd1);
        tick(1);
        lit("w1c_cap", bus0.readdata, m_rd[0], 32'h00000000);
        lit("w1c_irq", {31'd0, irq0}, {31'd0, m_irq[0]}, 32'd0);

        // clear of bit3 lands on the same edge that captures bit3
        pin = 16'hA5CB;
        tick(CAP_LAT - 1);
        bus_write(2'd3, 32'h00000008);
        tick(1);
        lit("collide_rise", bus0.readdata, m_rd[0], 32'h00000008);
        lit("collide_any", bus1.readdata, m_rd[1], 32'h00000008);
        bus_write(2'd3, 32'h0000FFFF);

        // falling edge on bit15 with mask clear, then unmask
        bus_write(2'd2, 32'h00000000);
        addr = 2'd3;
        pin  = 16'h25CB;
        tick(CAP_LAT + 3);
        lit("fall_any_cap", bus1.readdata, m_rd[1], 32'h00008000);
        lit("fall_rise_cap", bus0.readdata, m_rd[0], 32'h00000000);
        lit("fall_masked_irq", {31'd0, irq1}, {31'd0, m_irq[1]}, 32'd0);
        bus_write(2'd2, 32'h00008000);
        lit("unmask_irq_early", {31'd0, irq1}, {31'd0, m_irq[1]}, 32'd0);
        tick(1);
        lit("unmask_irq", {31'd0, irq1}, {31'd0, m_irq[1]}, 32'd1);
        lit("unmask_rise_irq", {31'd0, irq0}, {31'd0, m_irq[0]}, 32'd0);

        // reserved offset, mask readback, ignored writes
        addr = 2'd1;
        tick(1);
        lit("rsvd_read", bus0.readdata, m_rd[0], 32'd0);
        bus_write(2'd0, 32'h0000FFFF);
        bus_write(2'd1, 32'h0000FFFF);
        addr  = 2'd2;
        wdata = 32'h0000FFFF;
        wn    = 1'b0;
        tick(1);
        wn    = 1'b1;
        wdata = 32'd0;
        tick(1);
        lit("mask_read", bus0.readdata, m_rd[0], 32'h00008000);

        // reset mid-operation with irq pending
        reset = 1'b1;
        tick(1);
        lit("midrst_irq", {31'd0, irq1}, {31'd0, m_irq[1]}, 32'd0);
        lit("midrst_rd", bus0.readdata, m_rd[0], 32'd0);
        reset = 1'b0;
        tick(CAP_LAT + 3);

        // pattern sweep with all bits unmasked; the model checks every cycle
        bus_write(2'd2, 32'h0000FFFF);
        for (int p = 0; p < 5; p++) begin
            case (p)
                0:       pin = 16'h0000;
                1:       pin = 16'hFFFF;
                2:       pin = 16'h5555;
                3:       pin = 16'hAAAA;
                default: pin = 16'h0F0F;
            endcase
            addr = 2'd3;
            tick(CAP_LAT + 2);
            addr = 2'd0;
            tick(2);
            if (p[0]) bus_write(2'd3, 32'h0000FFFF);
        end

`ifdef PIO_DEBOUNCE_EN
        // short glitch is filtered, a long pulse is captured once
        pin = 16'h0000;
        tick(CAP_LAT + 4);
        bus_write(2'd3, 32'h0000FFFF);
        pin = 16'h0004;
        tick(5);
        pin = 16'h0000;
        addr = 2'd0;
        tick(CAP_LAT + 4);
        lit("glitch_data", bus0.readdata, m_rd[0], 32'd0);
        addr = 2'd3;
        tick(1);
        lit("glitch_cap", bus0.readdata, m_rd[0], 32'd0);
        pin = 16'h0004;
        tick(CAP_LAT + 4);
        lit("stable_cap", bus0.readdata, m_rd[0], 32'h00000004);
`endif

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
